// File: rtl/token_evaluator.sv
// rtl/token_evaluator.sv - left-to-right NUM (+|- NUM)* EOF evaluator with held result handshake
// Optional signed-overflow tracking: define EVAL_OVF_DETECT_EN.
module token_evaluator #(
    parameter int ACC_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             I_VALID,
    input  logic [15:0]      I_DATA,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic [ACC_W-1:0] O_DATA,
    output logic             ERROR,
    output logic             OVF,
    output logic             BUSY
);

    localparam logic [7:0] TAG_NUM   = 8'h00;
    localparam logic [7:0] TAG_PLUS  = 8'h01;
    localparam logic [7:0] TAG_MINUS = 8'h02;
    localparam logic [7:0] TAG_EOF   = 8'h03;

    typedef enum logic [1:0] {
        EXPECT_NUM,
        EXPECT_OP,
        SKIP,
        DONE
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic               pend_sub;

    logic [7:0]         tag;
    logic [ACC_W-1:0]   operand;
    logic [ACC_W-1:0]   next_acc;
    logic               num_step;
    logic               result_load;
    logic               handshake;

    assign tag       = I_DATA[15:8];
    assign operand   = {{(ACC_W-8){1'b0}}, I_DATA[7:0]};
    assign next_acc  = pend_sub ? (acc - operand) : (acc + operand);
    assign num_step  = (state == EXPECT_NUM) && I_VALID && (tag == TAG_NUM);
    // Every EOF outside DONE produces a result (good or error) on the next edge.
    assign result_load = (state != DONE) && I_VALID && (tag == TAG_EOF);
    assign handshake = (state == DONE) && O_READY;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= EXPECT_NUM;
            acc      <= '0;
            pend_sub <= 1'b0;
            O_VALID  <= 1'b0;
            O_DATA   <= '0;
            ERROR    <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            case (state)
                EXPECT_NUM: begin
                    if (I_VALID) begin
                        BUSY <= 1'b1;
                        if (tag == TAG_NUM) begin
                            acc   <= next_acc;
                            state <= EXPECT_OP;
                        end else if (tag == TAG_EOF) begin
                            O_VALID <= 1'b1;
                            O_DATA  <= '0;
                            ERROR   <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= SKIP;
                        end
                    end
                end
                EXPECT_OP: begin
                    if (I_VALID) begin
                        if (tag == TAG_PLUS || tag == TAG_MINUS) begin
                            pend_sub <= (tag == TAG_MINUS);
                            state    <= EXPECT_NUM;
                        end else if (tag == TAG_EOF) begin
                            O_VALID <= 1'b1;
                            O_DATA  <= acc;
                            ERROR   <= 1'b0;
                            state   <= DONE;
                        end else begin
                            state <= SKIP;
                        end
                    end
                end
                SKIP: begin
                    if (I_VALID && tag == TAG_EOF) begin
                        O_VALID <= 1'b1;
                        O_DATA  <= '0;
                        ERROR   <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // Incoming tokens are dropped here, including on the handshake cycle.
                    if (handshake) begin
                        O_VALID  <= 1'b0;
                        acc      <= '0;
                        pend_sub <= 1'b0;
                        BUSY     <= 1'b0;
                        state    <= EXPECT_NUM;
                    end
                end
                default: state <= EXPECT_NUM;
            endcase
        end
    end

`ifdef EVAL_OVF_DETECT_EN
    logic ovf_mark;
    logic ovf_r;
    logic step_ovf;

    // Operand is always non-negative, so only one sign direction can overflow per op.
    assign step_ovf = pend_sub ? (acc[ACC_W-1] & ~next_acc[ACC_W-1])
                               : (~acc[ACC_W-1] & next_acc[ACC_W-1]);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf_mark <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (handshake) begin
            ovf_mark <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (num_step && step_ovf) begin
            ovf_mark <= 1'b1;
        end else if (result_load) begin
            ovf_r <= ovf_mark;
        end
    end

    assign OVF = ovf_r;
`else
    logic unused_ovf;
    assign unused_ovf = num_step ^ result_load;
    assign OVF = 1'b0;
`endif

endmodule
